// File: rtl/exmem_pipe_reg.sv
// exmem_pipe_reg: EX/MEM stage register, valid/ready handshake,
// optional 2-entry skid buffer, synchronous flush, control squash.
// Ports: clock, reset_n (async low), flush; in_valid/in_ready + in_*
// fields from EX; out_valid/out_ready + out_* fields to MEM;
// occupancy = entries held (0..2).
module exmem_pipe_reg #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int SKID           = 1,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_zero,
  input  logic              in_lt,
  input  logic              in_gt,
  input  logic              in_branch,
  input  logic              in_mem_write,
  input  logic              in_mem_read,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_add_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_zero,
  output logic              out_lt,
  output logic              out_gt,
  output logic              out_branch,
  output logic              out_mem_write,
  output logic              out_mem_read,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_add_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_write_reg,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              zero;
    logic              lt;
    logic              gt;
    logic              branch;
    logic              mem_write;
    logic              mem_read;
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] add;
    logic [DATA_W-1:0] st;
    logic [REG_W-1:0]  wreg;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } st_t;

  st_t  state_q;
  st_t  state_d;
  logic rdy_q;
  ent_t din;
  ent_t main_q;
  ent_t skid_q;
  logic in_fire;
  logic out_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign din = '{
    zero:       in_zero,
    lt:         in_lt,
    gt:         in_gt,
    branch:     in_branch,
    mem_write:  in_mem_write,
    mem_read:   in_mem_read,
    mem_to_reg: in_mem_to_reg,
    reg_write:  in_reg_write,
    alu:        in_alu_result,
    add:        in_add_result,
    st:         in_store_data,
    wreg:       in_write_reg
  };

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // rdy_q tracks "next state is not FULL" so in_ready is a flop output
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (1'b1)
        (state_q == EMPTY): begin
          if (in_fire) begin
            state_d    = ONE;
            ld_main_in = 1'b1;
          end
        end
        (state_q == ONE): begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        (state_q == FULL): begin
          if (out_fire) begin
            state_d      = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    occupancy = state_q;
    if (SKID != 0) begin
      in_ready = rdy_q;
    end else begin
      in_ready = !out_valid || out_ready;
    end
    out_branch    = out_valid & main_q.branch;
    out_mem_write = out_valid & main_q.mem_write;
    out_mem_read  = out_valid & main_q.mem_read;
    out_reg_write = out_valid & main_q.reg_write;
    if (ZERO_REG_GUARD != 0 && main_q.wreg == '0) begin
      out_reg_write = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_q <= din;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= din;
      end
    end
  end

  assign out_zero       = main_q.zero;
  assign out_lt         = main_q.lt;
  assign out_gt         = main_q.gt;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_alu_result = main_q.alu;
  assign out_add_result = main_q.add;
  assign out_store_data = main_q.st;
  assign out_write_reg  = main_q.wreg;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// tb_exmem_pipe_reg: bench for exmem_pipe_reg, SKID=1 and SKID=0
// builds side by side, checked against a queue model every cycle.
module tb_exmem_pipe_reg;

  typedef struct packed {
    logic        zero;
    logic        lt;
    logic        gt;
    logic        branch;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] alu;
    logic [31:0] add;
    logic [31:0] st;
    logic [4:0]  wreg;
  } ent_t;

  logic clock = 1'b0;
  logic reset_n;
  logic flush;
  logic in_valid;
  logic out_ready;
  ent_t din;

  always #5 clock = ~clock;

  logic        o1_ready, o1_valid, o1_z, o1_lt, o1_gt, o1_br;
  logic        o1_mw, o1_mr, o1_m2r, o1_rw;
  logic [31:0] o1_alu, o1_add, o1_st;
  logic [4:0]  o1_wreg;
  logic [1:0]  o1_occ;

  logic        o0_ready, o0_valid, o0_z, o0_lt, o0_gt, o0_br;
  logic        o0_mw, o0_mr, o0_m2r, o0_rw;
  logic [31:0] o0_alu, o0_add, o0_st;
  logic [4:0]  o0_wreg;
  logic [1:0]  o0_occ;

  exmem_pipe_reg #(.SKID(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o1_ready),
    .in_zero(din.zero), .in_lt(din.lt), .in_gt(din.gt),
    .in_branch(din.branch), .in_mem_write(din.mem_write),
    .in_mem_read(din.mem_read), .in_mem_to_reg(din.mem_to_reg),
    .in_reg_write(din.reg_write), .in_alu_result(din.alu),
    .in_add_result(din.add), .in_store_data(din.st),
    .in_write_reg(din.wreg),
    .out_valid(o1_valid), .out_ready(out_ready),
    .out_zero(o1_z), .out_lt(o1_lt), .out_gt(o1_gt),
    .out_branch(o1_br), .out_mem_write(o1_mw),
    .out_mem_read(o1_mr), .out_mem_to_reg(o1_m2r),
    .out_reg_write(o1_rw), .out_alu_result(o1_alu),
    .out_add_result(o1_add), .out_store_data(o1_st),
    .out_write_reg(o1_wreg), .occupancy(o1_occ)
  );

  exmem_pipe_reg #(.SKID(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o0_ready),
    .in_zero(din.zero), .in_lt(din.lt), .in_gt(din.gt),
    .in_branch(din.branch), .in_mem_write(din.mem_write),
    .in_mem_read(din.mem_read), .in_mem_to_reg(din.mem_to_reg),
    .in_reg_write(din.reg_write), .in_alu_result(din.alu),
    .in_add_result(din.add), .in_store_data(din.st),
    .in_write_reg(din.wreg),
    .out_valid(o0_valid), .out_ready(out_ready),
    .out_zero(o0_z), .out_lt(o0_lt), .out_gt(o0_gt),
    .out_branch(o0_br), .out_mem_write(o0_mw),
    .out_mem_read(o0_mr), .out_mem_to_reg(o0_m2r),
    .out_reg_write(o0_rw), .out_alu_result(o0_alu),
    .out_add_result(o0_add), .out_store_data(o0_st),
    .out_write_reg(o0_wreg), .occupancy(o0_occ)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] a,
                              input logic [4:0] c,
                              input logic [4:0] w);
    ent_t e;
    e.zero = a[0];
    e.lt   = a[1];
    e.gt   = a[2];
    {e.branch, e.mem_write, e.mem_read, e.mem_to_reg, e.reg_write} = c;
    e.alu  = a;
    e.add  = a + 32'h1000;
    e.st   = ~a;
    e.wreg = w;
    return e;
  endfunction

  // Model: a FIFO of accepted entries (cap 2 or 1) plus the last
  // entry shown on the output, which the data fields keep when empty.
  ent_t q1[$];
  ent_t q0[$];
  ent_t last1 = '0;
  ent_t last0 = '0;
  bit   ir1, if1, of1, ir0, if0, of0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1.delete();
      q0.delete();
      last1 = '0;
      last0 = '0;
    end else begin
      ir1 = (q1.size() < 2);
      if1 = in_valid && ir1;
      of1 = (q1.size() != 0) && out_ready;
      ir0 = (q0.size() == 0) || out_ready;
      if0 = in_valid && ir0;
      of0 = (q0.size() != 0) && out_ready;
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (of1) void'(q1.pop_front());
        if (if1) q1.push_back(din);
        if (of0) void'(q0.pop_front());
        if (if0) q0.push_back(din);
      end
      if (q1.size() != 0) last1 = q1[0];
      if (q0.size() != 0) last0 = q0[0];
    end
  end

  ent_t e;
  bit   v;

  always @(negedge clock) begin
    if (chk_en) begin
      e = last1;
      v = (q1.size() != 0);
      chk("d1 valid", 64'(o1_valid), 64'(v));
      chk("d1 occ", 64'(o1_occ), 64'(q1.size()));
      chk("d1 in_ready", 64'(o1_ready), 64'(q1.size() < 2));
      chk("d1 ctrl", 64'({o1_br, o1_mw, o1_mr, o1_rw, o1_m2r}),
          64'({v & e.branch, v & e.mem_write, v & e.mem_read,
               v & e.reg_write & (e.wreg != 5'd0), e.mem_to_reg}));
      chk("d1 flags", 64'({o1_z, o1_lt, o1_gt}),
          64'({e.zero, e.lt, e.gt}));
      chk("d1 alu", 64'(o1_alu), 64'(e.alu));
      chk("d1 add", 64'(o1_add), 64'(e.add));
      chk("d1 store", 64'(o1_st), 64'(e.st));
      chk("d1 wreg", 64'(o1_wreg), 64'(e.wreg));
      e = last0;
      v = (q0.size() != 0);
      chk("d0 valid", 64'(o0_valid), 64'(v));
      chk("d0 occ", 64'(o0_occ), 64'(q0.size()));
      chk("d0 in_ready", 64'(o0_ready), 64'(!v || out_ready));
      chk("d0 ctrl", 64'({o0_br, o0_mw, o0_mr, o0_rw, o0_m2r}),
          64'({v & e.branch, v & e.mem_write, v & e.mem_read,
               v & e.reg_write & (e.wreg != 5'd0), e.mem_to_reg}));
      chk("d0 flags", 64'({o0_z, o0_lt, o0_gt}),
          64'({e.zero, e.lt, e.gt}));
      chk("d0 alu", 64'(o0_alu), 64'(e.alu));
      chk("d0 add", 64'(o0_add), 64'(e.add));
      chk("d0 store", 64'(o0_st), 64'(e.st));
      chk("d0 wreg", 64'(o0_wreg), 64'(e.wreg));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b1;
    chk("lit reset valid", 64'(o1_valid), 64'd0);
    chk("lit reset occ", 64'(o1_occ), 64'd0);
    chk("lit reset in_ready", 64'(o1_ready), 64'd1);
    chk("lit reset alu", 64'(o1_alu), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // stream 1,2,3
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      din      = mk(32'(i), 5'b00001, 5'd1);
      in_valid = 1'b1;
      step();
      chk("lit stream alu", 64'(o1_alu), 64'(i));
      chk("lit stream occ", 64'(o1_occ), 64'd1);
      chk("lit stream in_ready", 64'(o1_ready), 64'd1);
      chk("lit stream reg_write", 64'(o1_rw), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("lit stream drain occ", 64'(o1_occ), 64'd0);

    // back-pressure A then B
    out_ready = 1'b0;
    din       = mk(32'h10, 5'b00010, 5'd2);
    in_valid  = 1'b1;
    step();
    chk("lit bp A occ", 64'(o1_occ), 64'd1);
    chk("lit bp A in_ready", 64'(o1_ready), 64'd1);
    din = mk(32'h20, 5'b00110, 5'd4);
    step();
    chk("lit bp B occ", 64'(o1_occ), 64'd2);
    chk("lit bp B in_ready", 64'(o1_ready), 64'd0);
    chk("lit bp head alu", 64'(o1_alu), 64'h10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("lit bp second alu", 64'(o1_alu), 64'h20);
    chk("lit bp second occ", 64'(o1_occ), 64'd1);
    chk("lit bp in_ready back", 64'(o1_ready), 64'd1);
    step();
    chk("lit bp empty valid", 64'(o1_valid), 64'd0);

    // flush while full, C offered in same cycle
    out_ready = 1'b0;
    din       = mk(32'h30, 5'b11001, 5'd3);
    in_valid  = 1'b1;
    step();
    din = mk(32'h40, 5'b11101, 5'd5);
    step();
    chk("lit flush pre occ", 64'(o1_occ), 64'd2);
    din   = mk(32'h50, 5'b11111, 5'd6);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("lit flush valid", 64'(o1_valid), 64'd0);
    chk("lit flush occ", 64'(o1_occ), 64'd0);
    chk("lit flush ctrl", 64'({o1_mw, o1_rw, o1_br}), 64'd0);
    chk("lit flush held alu", 64'(o1_alu), 64'h30);
    repeat (3) step();
    chk("lit flush C absent", 64'(o1_valid), 64'd0);

    // zero-register guard
    out_ready = 1'b1;
    din       = mk(32'h60, 5'b00001, 5'd0);
    in_valid  = 1'b1;
    step();
    chk("lit guard r0 valid", 64'(o1_valid), 64'd1);
    chk("lit guard r0 reg_write", 64'(o1_rw), 64'd0);
    din = mk(32'h61, 5'b00001, 5'd7);
    step();
    chk("lit guard r7 reg_write", 64'(o1_rw), 64'd1);
    chk("lit guard r7 wreg", 64'(o1_wreg), 64'd7);
    in_valid = 1'b0;
    step();

    // async reset while full
    out_ready = 1'b0;
    din       = mk(32'h80, 5'b11011, 5'd9);
    in_valid  = 1'b1;
    step();
    din = mk(32'h81, 5'b01001, 5'd10);
    step();
    in_valid = 1'b0;
    chk("lit ar pre occ", 64'(o1_occ), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("lit ar valid", 64'(o1_valid), 64'd0);
    chk("lit ar occ", 64'(o1_occ), 64'd0);
    chk("lit ar in_ready", 64'(o1_ready), 64'd1);
    chk("lit ar alu", 64'(o1_alu), 64'd0);
    chk("lit ar ctrl", 64'({o1_br, o1_mw, o1_m2r, o1_rw}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("lit ar post in_ready", 64'(o1_ready), 64'd1);
    chk("lit ar post occ", 64'(o1_occ), 64'd0);

    // SKID=0: combinational in_ready
    out_ready = 1'b0;
    din       = mk(32'h70, 5'b00001, 5'd1);
    in_valid  = 1'b1;
    #1;
    chk("lit s0 ready empty", 64'(o0_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("lit s0 valid", 64'(o0_valid), 64'd1);
    chk("lit s0 ready stalled", 64'(o0_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("lit s0 ready follows hi", 64'(o0_ready), 64'd1);
    out_ready = 1'b0;
    #1;
    chk("lit s0 ready follows lo", 64'(o0_ready), 64'd0);
    din      = mk(32'h71, 5'b00001, 5'd2);
    in_valid = 1'b1;
    step();
    chk("lit s0 occ max", 64'(o0_occ), 64'd1);
    chk("lit s0 held alu", 64'(o0_alu), 64'h70);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("lit end d1 empty", 64'(o1_occ), 64'd0);

    @(negedge clock);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
